// File: rtl/cache_line_refill.sv
// Line transfer engine: writes a dirty victim line back to memory, then refills the line
// word by word from memory through the line's write port.

`ifndef CACHE_T
`define CACHE_T 26
`endif
`ifndef CACHE_S
`define CACHE_S 2
`endif
`ifndef CACHE_B
`define CACHE_B 4
`endif

module cache_line_refill #(
  parameter int unsigned TAG_WIDTH  = `CACHE_T,
  parameter int unsigned SET_WIDTH  = `CACHE_S,
  parameter int unsigned LINE_WIDTH = `CACHE_B,
  parameter int unsigned LINE_SIZE  = 2**(LINE_WIDTH-2)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  victim_dirty,
  input  logic [TAG_WIDTH-1:0]  victim_tag,
  input  logic [TAG_WIDTH-1:0]  new_tag,
  input  logic [SET_WIDTH-1:0]  set_index,
  output logic                  busy,
  output logic                  done,
  output logic                  line_en,
  output logic [TAG_WIDTH-1:0]  line_target,
  output logic [LINE_WIDTH-1:0] line_index,
  output logic                  line_write_en,
  output logic [TAG_WIDTH-1:0]  line_set_tag,
  output logic                  line_set_dirty,
  output logic [31:0]           line_wdata,
  input  logic [31:0]           line_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ready,
  input  logic [31:0]           mem_rdata
);

  localparam int unsigned CntWidth = LINE_WIDTH - 2;

  if (TAG_WIDTH + SET_WIDTH + LINE_WIDTH != 32) begin : gen_width_check
    $fatal(1, "cache_line_refill: TAG_WIDTH+SET_WIDTH+LINE_WIDTH must equal 32");
  end

  typedef enum logic [1:0] {StIdle, StWb, StFill, StDone} state_e;

  state_e                state_q, state_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [TAG_WIDTH-1:0]  vtag_q, vtag_d;
  logic [TAG_WIDTH-1:0]  ntag_q, ntag_d;
  logic [SET_WIDTH-1:0]  set_q, set_d;
  logic                  last_word;

  assign last_word      = (cnt_q == CntWidth'(LINE_SIZE - 1));
  assign line_set_dirty = 1'b0;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    vtag_d        = vtag_q;
    ntag_d        = ntag_q;
    set_d         = set_q;
    busy          = (state_q != StIdle);
    done          = 1'b0;
    line_en       = 1'b0;
    line_target   = '0;
    line_index    = '0;
    line_write_en = 1'b0;
    line_set_tag  = '0;
    line_wdata    = '0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          vtag_d  = victim_tag;
          ntag_d  = new_tag;
          set_d   = set_index;
          cnt_d   = '0;
          state_d = victim_dirty ? StWb : StFill;
        end
      end
      StWb: begin
        mem_req     = 1'b1;
        mem_we      = 1'b1;
        mem_addr    = {vtag_q, set_q, cnt_q, 2'b00};
        mem_wdata   = line_rdata;
        line_en     = 1'b1;
        line_target = vtag_q;
        line_index  = {cnt_q, 2'b00};
        if (mem_ready) begin
          if (last_word) begin
            cnt_d   = '0;
            state_d = StFill;
          end else begin
            cnt_d = cnt_q + CntWidth'(1);
          end
        end
      end
      StFill: begin
        mem_req     = 1'b1;
        mem_addr    = {ntag_q, set_q, cnt_q, 2'b00};
        // Line keeps matching the old tag until the final word lands with the new one.
        line_target = vtag_q;
        line_index  = {cnt_q, 2'b00};
        if (mem_ready) begin
          line_en       = 1'b1;
          line_write_en = 1'b1;
          line_wdata    = mem_rdata;
          line_set_tag  = last_word ? ntag_q : vtag_q;
          if (last_word) begin
            cnt_d   = '0;
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + CntWidth'(1);
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      vtag_q  <= '0;
      ntag_q  <= '0;
      set_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vtag_q  <= vtag_d;
      ntag_q  <= ntag_d;
      set_q   <= set_d;
    end
  end

endmodule

// File: tb/tb_cache_line_refill.sv
// Directed bench for cache_line_refill with TAG=26, SET=2, LINE=4 (four words per line).
`timescale 1ns/1ps

module tb_cache_line_refill;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        victim_dirty;
  logic [25:0] victim_tag;
  logic [25:0] new_tag;
  logic [1:0]  set_index;
  logic        busy;
  logic        done;
  logic        line_en;
  logic [25:0] line_target;
  logic [3:0]  line_index;
  logic        line_write_en;
  logic [25:0] line_set_tag;
  logic        line_set_dirty;
  logic [31:0] line_wdata;
  logic [31:0] line_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  logic [31:0] line_mem [4];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign line_rdata = line_mem[line_index[3:2]];
  assign mem_rdata  = mem_ready ? (32'hD000_0000 ^ mem_addr) : 32'h0;

  cache_line_refill #(
    .TAG_WIDTH (26),
    .SET_WIDTH (2),
    .LINE_WIDTH(4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .victim_dirty  (victim_dirty),
    .victim_tag    (victim_tag),
    .new_tag       (new_tag),
    .set_index     (set_index),
    .busy          (busy),
    .done          (done),
    .line_en       (line_en),
    .line_target   (line_target),
    .line_index    (line_index),
    .line_write_en (line_write_en),
    .line_set_tag  (line_set_tag),
    .line_set_dirty(line_set_dirty),
    .line_wdata    (line_wdata),
    .line_rdata    (line_rdata),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata)
  );

  // Leaves the bench #1 into cycle 1 of the transfer.
  task automatic start_xfer(input logic dirty, input logic [25:0] vt, input logic [25:0] nt,
                            input logic [1:0] si);
    @(posedge clk); #1;
    victim_dirty = dirty;
    victim_tag   = vt;
    new_tag      = nt;
    set_index    = si;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; victim_dirty = 1'b0; mem_ready = 1'b0;
    victim_tag = '0; new_tag = '0; set_index = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({busy, done, mem_req, mem_we, line_en, line_write_en, line_set_dirty} !== 7'b0) begin
      fails++;
      $display("FAIL reset_ctrl got %b exp 0000000",
               {busy, done, mem_req, mem_we, line_en, line_write_en, line_set_dirty});
    end
    tests++;
    if ({mem_addr, mem_wdata, line_wdata} !== 96'h0) begin
      fails++;
      $display("FAIL reset_data got %h %h %h exp 0", mem_addr, mem_wdata, line_wdata);
    end
    tests++;
    if ({line_index, line_target, line_set_tag} !== 56'h0) begin
      fails++;
      $display("FAIL reset_line got %h %h %h exp 0", line_index, line_target, line_set_tag);
    end
    reset = 1'b1;
  endtask

  task automatic test_clean_miss();
    logic [31:0] ea;
    mem_ready = 1'b1;
    start_xfer(1'b0, 26'd9, 26'd5, 2'd1);
    for (int c = 1; c <= 6; c++) begin
      if (c <= 4) begin
        ea = 32'h150 + 32'(4 * (c - 1));
        tests++;
        if ({busy, done, mem_req, mem_we, line_en, line_write_en} !== 6'b101011) begin
          fails++;
          $display("FAIL clean_ctrl c=%0d got %b exp 101011", c,
                   {busy, done, mem_req, mem_we, line_en, line_write_en});
        end
        tests++;
        if (mem_addr !== ea || line_index !== 4'(4 * (c - 1))) begin
          fails++;
          $display("FAIL clean_addr c=%0d got %h/%h exp %h/%h", c, mem_addr, line_index,
                   ea, 4'(4 * (c - 1)));
        end
        tests++;
        if (line_wdata !== (32'hD000_0000 ^ ea)) begin
          fails++;
          $display("FAIL clean_wdata c=%0d got %h exp %h", c, line_wdata, 32'hD000_0000 ^ ea);
        end
        tests++;
        if (line_set_tag !== ((c == 4) ? 26'd5 : 26'd9) || line_target !== 26'd9) begin
          fails++;
          $display("FAIL clean_tag c=%0d got set=%0d tgt=%0d exp set=%0d tgt=9", c,
                   line_set_tag, line_target, (c == 4) ? 5 : 9);
        end
      end else begin
        tests++;
        if ({busy, done, mem_req, line_en} !== ((c == 5) ? 4'b1100 : 4'b0000)) begin
          fails++;
          $display("FAIL clean_done c=%0d got %b exp %b", c, {busy, done, mem_req, line_en},
                   (c == 5) ? 4'b1100 : 4'b0000);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_dirty_miss();
    logic [31:0] ea;
    int k;
    for (int i = 0; i < 4; i++) line_mem[i] = 32'hA000_0000 + 32'(i);
    mem_ready = 1'b1;
    start_xfer(1'b1, 26'd3, 26'd7, 2'd2);
    for (int c = 1; c <= 10; c++) begin
      k = (c - 1) % 4;
      if (c <= 4) begin
        ea = 32'hE0 + 32'(4 * k);
        tests++;
        if ({busy, done, mem_req, mem_we, line_en, line_write_en} !== 6'b101110 ||
            mem_addr !== ea || mem_wdata !== 32'hA000_0000 + 32'(k) || line_target !== 26'd3) begin
          fails++;
          $display("FAIL dirty_wb c=%0d got ctl=%b addr=%h wd=%h tgt=%0d exp 101110 %h %h 3", c,
                   {busy, done, mem_req, mem_we, line_en, line_write_en}, mem_addr, mem_wdata,
                   line_target, ea, 32'hA000_0000 + 32'(k));
        end
      end else if (c <= 8) begin
        ea = 32'h1E0 + 32'(4 * k);
        tests++;
        if ({busy, done, mem_req, mem_we, line_en, line_write_en} !== 6'b101011 ||
            mem_addr !== ea || line_wdata !== (32'hD000_0000 ^ ea) ||
            line_set_tag !== ((k == 3) ? 26'd7 : 26'd3)) begin
          fails++;
          $display("FAIL dirty_fill c=%0d got ctl=%b addr=%h wd=%h tag=%0d exp 101011 %h %h %0d",
                   c, {busy, done, mem_req, mem_we, line_en, line_write_en}, mem_addr,
                   line_wdata, line_set_tag, ea, 32'hD000_0000 ^ ea, (k == 3) ? 7 : 3);
        end
      end else begin
        tests++;
        if ({busy, done, mem_req} !== ((c == 9) ? 3'b110 : 3'b000)) begin
          fails++;
          $display("FAIL dirty_done c=%0d got %b exp %b", c, {busy, done, mem_req},
                   (c == 9) ? 3'b110 : 3'b000);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] ea;
    logic        wb;
    logic        rdy;
    int k;
    mem_ready = 1'b0;
    start_xfer(1'b1, 26'd3, 26'd7, 2'd2);
    for (int c = 1; c <= 18; c++) begin
      rdy = (c % 2 == 0);
      mem_ready = rdy;
      #1;
      if (c <= 16) begin
        k  = ((c - 1) / 2) % 4;
        wb = (c <= 8);
        ea = (wb ? 32'hE0 : 32'h1E0) + 32'(4 * k);
        tests++;
        if ({busy, done, mem_req, mem_we, line_en, line_write_en} !==
            {3'b101, wb, wb | rdy, ~wb & rdy}) begin
          fails++;
          $display("FAIL wait_ctrl c=%0d got %b exp %b", c,
                   {busy, done, mem_req, mem_we, line_en, line_write_en},
                   {3'b101, wb, wb | rdy, ~wb & rdy});
        end
        tests++;
        if (mem_addr !== ea || line_index !== 4'(4 * k) ||
            (wb && mem_wdata !== 32'hA000_0000 + 32'(k))) begin
          fails++;
          $display("FAIL wait_stable c=%0d got %h/%h/%h exp %h/%h", c, mem_addr, line_index,
                   mem_wdata, ea, 4'(4 * k));
        end
      end else begin
        tests++;
        if ({busy, done} !== ((c == 17) ? 2'b11 : 2'b00)) begin
          fails++;
          $display("FAIL wait_done c=%0d got %b exp %b", c, {busy, done},
                   (c == 17) ? 2'b11 : 2'b00);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_start_ignored();
    int nwr = 0;
    int t   = 0;
    mem_ready = 1'b1;
    start_xfer(1'b0, 26'd9, 26'd5, 2'd1);
    for (int c = 1; c <= 7; c++) begin
      start = (c == 2 || c == 5 || c == 6);
      if (c <= 6 && line_en && line_write_en) nwr++;
      if (c == 5 || c == 6) begin
        tests++;
        if ({busy, done} !== ((c == 5) ? 2'b11 : 2'b00)) begin
          fails++;
          $display("FAIL ign_state c=%0d got %b exp %b", c, {busy, done},
                   (c == 5) ? 2'b11 : 2'b00);
        end
      end
      if (c == 7) begin
        tests++;
        if (busy !== 1'b1 || mem_addr !== 32'h150) begin
          fails++;
          $display("FAIL ign_restart got busy=%b addr=%h exp busy=1 addr=00000150", busy,
                   mem_addr);
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    tests++;
    if (nwr != 4) begin
      fails++;
      $display("FAIL ign_writes got %0d exp 4", nwr);
    end
    while (done !== 1'b1 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL ign_drain got done=%b exp 1 within 20 cycles", done);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    int t = 0;
    mem_ready = 1'b1;
    start_xfer(1'b0, 26'd9, 26'd5, 2'd1);
    for (int c = 1; c <= 6; c++) begin
      if (c == 3) reset = 1'b0;
      if (c == 4) reset = 1'b1;
      if (c >= 4) begin
        tests++;
        if ({busy, done, mem_req, line_en, line_write_en} !== 5'b0 || mem_addr !== 32'h0) begin
          fails++;
          $display("FAIL abort_idle c=%0d got %b addr=%h exp 00000 addr=0", c,
                   {busy, done, mem_req, line_en, line_write_en}, mem_addr);
        end
      end
      @(posedge clk); #1;
    end
    start_xfer(1'b0, 26'd9, 26'd5, 2'd1);
    tests++;
    if (mem_addr !== 32'h150 || line_index !== 4'd0 || line_set_tag !== 26'd9) begin
      fails++;
      $display("FAIL abort_restart got addr=%h idx=%h tag=%0d exp 00000150 0 9", mem_addr,
               line_index, line_set_tag);
    end
    while (done !== 1'b1 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL abort_drain got done=%b exp 1 within 20 cycles", done);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) line_mem[i] = 32'h0;
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_wait_states();
    test_start_ignored();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cache_line_refill.md
# cache_line_refill

Line transfer engine between one cache set and main memory. On a miss, the cache controller pulses `start`. If the victim line is dirty, the engine first writes the victim's words back to memory. It then fetches the new line word by word and writes it into the cache line through the line's `en`/`write_en`/`set_tag`/`data`/`index` write port. It is the memory-facing counterpart of the per-line storage: it reads the line out for writeback and writes it during refill.

## Interface
- `TAG_WIDTH`, default `` `CACHE_T ``: tag bits.
- `SET_WIDTH`, default `` `CACHE_S ``: set-index bits.
- `LINE_WIDTH`, default `` `CACHE_B ``: byte-offset bits per line.
- `LINE_SIZE`, default `2**(LINE_WIDTH-2)`: words per line.
- `TAG_WIDTH+SET_WIDTH+LINE_WIDTH` must equal 32; elaboration fails otherwise.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-low (0 = reset).
- `start` in 1: request; sampled only in IDLE.
- `victim_dirty` in 1: victim needs writeback.
- `victim_tag` in TAG_WIDTH: tag currently held by the line.
- `new_tag` in TAG_WIDTH: tag to fetch.
- `set_index` in SET_WIDTH: set of the line.
- `busy` out 1: high when not IDLE.
- `done` out 1: one-cycle completion pulse.
- `line_en` out 1: line enable.
- `line_target` out TAG_WIDTH: tag presented for line hit match.
- `line_index` out LINE_WIDTH: byte index, equal to `{cnt, 2'b00}`.
- `line_write_en` out 1: line write strobe.
- `line_set_tag` out TAG_WIDTH: tag written with the data.
- `line_set_dirty` out 1: always 0.
- `line_wdata` out 32: word written into the line.
- `line_rdata` in 32: line read data, combinational from `line_index`.
- `mem_req` out 1: memory request.
- `mem_we` out 1: 1 = write, 0 = read.
- `mem_addr` out 32: word address.
- `mem_wdata` out 32: write data.
- `mem_ready` in 1: transfer completes on a rising edge where `mem_req && mem_ready`.
- `mem_rdata` in 32: read data, valid when `mem_ready` is high.

## Operation
- States: IDLE, WB, FILL, DONE. Word counter `cnt` is `LINE_WIDTH-2` bits wide.
- IDLE, on `start`:
  - Latch `victim_tag`, `new_tag`, `set_index`.
  - Set `cnt` = 0.
  - Go to WB if `victim_dirty`, else go to FILL.
- WB:
  - Drive `mem_req`=1, `mem_we`=1.
  - `mem_addr` = `{victim_tag, set_index, cnt, 2'b00}`.
  - `mem_wdata` = `line_rdata`, combinational.
  - `line_en`=1, `line_write_en`=0, `line_target`=victim_tag.
  - On handshake: `cnt++`. On the handshake of the last word (`cnt == LINE_SIZE-1`), go to FILL with `cnt` = 0.
- FILL:
  - Drive `mem_req`=1, `mem_we`=0.
  - `mem_addr` = `{new_tag, set_index, cnt, 2'b00}`.
  - `line_target` = victim_tag for the whole fill, so the line keeps hitting while it is being written.
  - On a handshake cycle only: `line_en`=1, `line_write_en`=1, `line_wdata`=`mem_rdata`.
  - `line_set_tag` = `new_tag` only on the last word, `victim_tag` on all other words. The tag therefore switches atomically with the final word.
  - On the handshake of the last word, go to DONE.
- DONE: `done`=1 for one cycle, then return to IDLE.
- `start` is ignored in WB, FILL and DONE; there is no queuing.
- Outside WB and FILL, every `mem_*` and `line_*` output is 0.

## Timing
- Reset (`reset`=0 at a rising edge):
  - State goes to IDLE and `cnt` to 0.
  - The next cycle shows `busy`=0, `done`=0, `mem_req`=0, `line_en`=0, `line_write_en`=0, all addresses and data 0.
  - Reset mid-transfer aborts immediately. No further line writes occur. A partially filled line keeps `victim_tag`.
- Handshake rules:
  - While `mem_req`=1 and `mem_ready`=0, `mem_addr`, `mem_we`, `mem_wdata` and `line_index` stay stable.
  - `line_write_en` stays 0 while waiting on `mem_ready`.
  - `mem_ready` is ignored when `mem_req`=0.
- Latency from the `start` edge (cycle 0), with `mem_ready` tied high and N = LINE_SIZE:
  - Clean miss: FILL during cycles 1..N, `done` in cycle N+1, `busy` high for cycles 1..N+1.
  - Dirty miss: WB during cycles 1..N, FILL during N+1..2N, `done` in cycle 2N+1.
  - Each wait cycle adds one cycle.
- `cnt` wraps to 0 at the WB→FILL transition. No transfer exceeds N words.

## Test plan
All scenarios use TAG_WIDTH=26, SET_WIDTH=2, LINE_WIDTH=4 (N=4).
- Clean miss, `new_tag`=5, `set_index`=1, `mem_ready`=1:
  - Reads at 0x150, 0x154, 0x158, 0x15C.
  - Four line writes of `mem_rdata` at `line_index` 0, 4, 8, 12.
  - `line_set_tag`=victim_tag on words 0-2 and =5 on word 3.
  - `done` in cycle 5.
- Dirty miss, `victim_tag`=3, `set_index`=2, line holds A0..A3, `new_tag`=7:
  - Memory writes (0xE0,A0), (0xE4,A1), (0xE8,A2), (0xEC,A3).
  - Then reads at 0x1E0..0x1EC.
  - `done` in cycle 9.
- `mem_ready` alternating 0/1 during a dirty miss: `mem_addr` and `mem_wdata` stay stable across wait cycles, there are no line writes on wait cycles, and `done` arrives in cycle 17.
- `start` pulsed during FILL and again in the DONE cycle: both are ignored. Exactly one transfer occurs, and a `start` pulse in the following IDLE cycle is accepted.
- `reset`=0 after the second FILL handshake:
  - Next cycle: `mem_req`=0, `busy`=0, `done`=0, and no further line writes.
  - A new `start` begins again at word 0 (address 0x150 in the clean-miss setup).
